// File: rtl/flappy_pkg.sv
// Shared game definitions: state encoding, keyboard event codes, screen geometry, score increment.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: none. Optional macro SCORE_BCD_EN selects a 4-digit packed BCD score.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DEAD = 2'd2
  } game_state_t;

  typedef enum logic [1:0] {
    KEY_NONE  = 2'd0,
    KEY_MAKE  = 2'd1,
    KEY_BREAK = 2'd2
  } key_evt_t;

  // Screen geometry, shared with the renderer
  localparam logic [9:0] Y_START = 10'd228;
  localparam logic [9:0] Y_MAX   = 10'd456;

  // Saturating score increment; binary by default, BCD when SCORE_BCD_EN is defined
  function automatic logic [15:0] score_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        carry;
    r = s;
`ifdef SCORE_BCD_EN
    carry = 1'b1;
    if (s != 16'h9999) begin
      for (int d = 0; d < 4; d++) begin
        if (carry) begin
          if (s[d*4 +: 4] >= 4'd9) begin
            r[d*4 +: 4] = 4'd0;
          end else begin
            r[d*4 +: 4] = s[d*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
`else
    carry = (s != 16'hFFFF);
    if (carry) r = s + 16'd1;
`endif
    return r;
  endfunction

endpackage

// File: rtl/flappy_game_state_if.sv
// Bundle between the game engine, the keyboard front end and the renderer.
// Latency: none (wires only).
// Backpressure: keyboard holds iSpaceState until oKeyAck; renderer outputs are never stalled.
interface flappy_game_state_if;
  logic [1:0]  iSpaceState;
  logic        oKeyAck;
  logic [9:0]  oBirdY;
  logic [15:0] oScore;
  logic [1:0]  oState;
  logic        oFrameTick;

  // Game engine side
  modport master (
    input  iSpaceState,
    output oKeyAck, oBirdY, oScore, oState, oFrameTick
  );

  // Keyboard / renderer side
  modport slave (
    output iSpaceState,
    input  oKeyAck, oBirdY, oScore, oState, oFrameTick
  );
endinterface

// File: rtl/flappy_game_state_frame_tick_gen.sv
// Free-running frame divider producing a one-cycle tick every TICK_DIV clocks.
// Latency: tick is registered, high the cycle after the counter reaches TICK_DIV-1.
// Backpressure: none; runs in every game state.
module frame_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clock,
  input  logic resetn,
  output logic oTick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..TICK_DIV-1 and pulse on wrap; phase restarts at 0 out of reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      oTick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      oTick <= 1'b1;
    end else begin
      cnt   <= cnt + 1'b1;
      oTick <= 1'b0;
    end
  end

endmodule

// File: rtl/flappy_game_state.sv
// Game FSM and bird physics: consumes spacebar events, steps gravity/flap per frame, keeps score.
// Latency: key ack one cycle after acceptance; physics outputs update one cycle after a frame tick.
// Backpressure: one event per ack pulse, ack low at least one cycle between. SCORE_BCD_EN selects BCD score.
module flappy_game_state
  import flappy_pkg::*;
#(
  parameter int TICK_DIV    = 833333,
  parameter int GRAVITY     = 1,
  parameter int FLAP_VEL    = 8,
  parameter int MAX_VEL     = 12,
  parameter int PIPE_PERIOD = 90
) (
  input  logic                 clock,
  input  logic                 resetn,
  flappy_game_state_if.master  bus
);

  localparam int PW = (PIPE_PERIOD > 1) ? $clog2(PIPE_PERIOD) : 1;
  localparam logic [PW-1:0]      PIPE_LAST = PW'(PIPE_PERIOD - 1);
  localparam logic signed [8:0]  GRAV9     = 9'(GRAVITY);
  localparam logic signed [8:0]  MAXV9     = 9'(MAX_VEL);
  localparam logic signed [7:0]  FLAPV8    = 8'(-FLAP_VEL);
  localparam logic signed [11:0] YMAX12    = 12'(Y_MAX);

  game_state_t        state;
  logic [9:0]         bird_y;
  logic signed [7:0]  vel;
  logic               flap_pending;
  logic [PW-1:0]      pipe_cnt;
  logic [15:0]        score;
  logic               key_ack;
  logic               tick;

  logic               accept;
  logic               make_evt;
  logic               flap;
  logic signed [8:0]  vel_sum;
  logic signed [7:0]  vel_fall;
  logic signed [7:0]  vel_new;
  logic signed [11:0] y_next;
  logic               hit_ceiling;
  logic               hit_floor;

  frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock  (clock),
    .resetn (resetn),
    .oTick  (tick)
  );

  // Event acceptance: code 3 is neither make nor break, so it is never acknowledged
  assign accept   = ((bus.iSpaceState == KEY_MAKE) || (bus.iSpaceState == KEY_BREAK)) && !key_ack;
  assign make_evt = accept && (bus.iSpaceState == KEY_MAKE);

  // Next-frame velocity and position; a make in the tick cycle counts for that tick
  always_comb begin
    flap        = flap_pending | make_evt;
    vel_sum     = {vel[7], vel} + GRAV9;
    vel_fall    = (vel_sum > MAXV9) ? MAXV9[7:0] : vel_sum[7:0];
    vel_new     = flap ? FLAPV8 : vel_fall;
    y_next      = $signed({2'b00, bird_y}) + $signed({{4{vel_new[7]}}, vel_new});
    hit_ceiling = y_next[11];
    hit_floor   = !y_next[11] && (y_next >= YMAX12);
  end

  // Game FSM with physics and score registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      bird_y       <= Y_START;
      vel          <= '0;
      flap_pending <= 1'b0;
      pipe_cnt     <= '0;
      score        <= '0;
      key_ack      <= 1'b0;
    end else begin
      key_ack <= accept;
      unique case (state)
        ST_IDLE: begin
          bird_y <= Y_START;
          vel    <= '0;
          if (make_evt) begin
            state        <= ST_PLAY;
            score        <= '0;
            pipe_cnt     <= '0;
            flap_pending <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (tick) begin
            flap_pending <= 1'b0;
            if (hit_ceiling) begin
              bird_y <= '0;
              vel    <= '0;
            end else if (hit_floor) begin
              bird_y <= Y_MAX;
              vel    <= vel_new;
              state  <= ST_DEAD;
            end else begin
              bird_y <= y_next[9:0];
              vel    <= vel_new;
            end
            // A death tick earns no point
            if (!hit_floor) begin
              if (pipe_cnt == PIPE_LAST) begin
                pipe_cnt <= '0;
                score    <= score_inc(score);
              end else begin
                pipe_cnt <= pipe_cnt + 1'b1;
              end
            end
          end else if (make_evt) begin
            flap_pending <= 1'b1;
          end
        end
        ST_DEAD: begin
          if (make_evt) begin
            state        <= ST_IDLE;
            bird_y       <= Y_START;
            vel          <= '0;
            flap_pending <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.oKeyAck    = key_ack;
  assign bus.oBirdY     = bird_y;
  assign bus.oScore     = score;
  assign bus.oState     = state;
  assign bus.oFrameTick = tick;

endmodule

// File: tb/tb_flappy_game_state.sv
// Bench for flappy_game_state: directed scenarios then random keyboard traffic vs a frame-level model.
// Latency: outputs compared 1 time unit after every rising clock edge.
// Backpressure: keyboard model drops its event the cycle after seeing oKeyAck.
module tb_flappy_game_state;

  localparam int TD = 4;
  localparam int PP = 3;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  flappy_game_state_if bus ();

  flappy_game_state #(
    .TICK_DIV    (TD),
    .GRAVITY     (1),
    .FLAP_VEL    (8),
    .MAX_VEL     (12),
    .PIPE_PERIOD (PP)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state (plain integers)
  int m_state, m_y, m_vel, m_pipe, m_score, m_n, m_phys;
  bit m_fp, m_ack, m_tick;
  bit rand_mode = 1'b0;

  function automatic int score_next(input int s);
`ifdef SCORE_BCD_EN
    int dec;
    dec = (s >> 12 & 15) * 1000 + (s >> 8 & 15) * 100 + (s >> 4 & 15) * 10 + (s & 15);
    if (dec < 9999) dec = dec + 1;
    return ((dec / 1000) << 12) | (((dec / 100) % 10) << 8) | (((dec / 10) % 10) << 4) | (dec % 10);
`else
    return (s < 65535) ? s + 1 : s;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0; m_y = 228; m_vel = 0; m_fp = 0; m_pipe = 0;
    m_score = 0; m_ack = 0; m_tick = 0; m_n = 0;
  endtask

  // One clock of game behaviour, from the rules: ack, frame physics, score
  task automatic model_step(input int key);
    bit accept, make;
    int v, yn;
    accept = ((key == 1) || (key == 2)) && !m_ack;
    make   = accept && (key == 1);
    if (m_state == 0) begin
      if (make) begin m_state = 1; m_score = 0; m_pipe = 0; m_fp = 1; end
    end else if (m_state == 1) begin
      if (m_tick) begin
        m_phys++;
        if (m_fp || make) v = -8;
        else v = (m_vel + 1 > 12) ? 12 : m_vel + 1;
        m_fp = 0;
        yn = m_y + v;
        if (yn < 0) begin m_y = 0; m_vel = 0; end
        else if (yn >= 456) begin m_y = 456; m_state = 2; end
        else begin m_y = yn; m_vel = v; end
        if (m_state == 1) begin
          m_pipe++;
          if (m_pipe == PP) begin m_pipe = 0; m_score = score_next(m_score); end
        end
      end else if (make) begin
        m_fp = 1;
      end
    end else begin
      if (make) begin m_state = 0; m_y = 228; m_vel = 0; end
    end
    m_ack  = accept;
    m_n++;
    m_tick = (m_n % TD) == 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: step model, compare everything, then act as the keyboard
  task automatic cycle();
    int k;
    k = int'(bus.iSpaceState);
    @(posedge clock);
    if (!resetn) model_reset();
    else model_step(k);
    #1;
    check("state", bus.oState, m_state);
    check("bird_y", bus.oBirdY, m_y);
    check("score", bus.oScore, m_score);
    check("key_ack", bus.oKeyAck, m_ack);
    check("frame_tick", bus.oFrameTick, m_tick);
    if (bus.oKeyAck === 1'b1) begin
      bus.iSpaceState = 2'd0;
    end else if (rand_mode) begin
      if (bus.iSpaceState == 2'd3) begin
        if ($urandom_range(0, 3) == 0) bus.iSpaceState = 2'd0;
      end else if (bus.iSpaceState == 2'd0 && $urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 19))
          0, 1, 2: bus.iSpaceState = 2'd3;
          3, 4, 5, 6, 7: bus.iSpaceState = 2'd2;
          default: bus.iSpaceState = 2'd1;
        endcase
      end
    end
  endtask

  task automatic press(input logic [1:0] code);
    bus.iSpaceState = code;
    cycle();
    cycle();
  endtask

  task automatic wait_phys_to(input int target);
    int guard;
    guard = 0;
    while (m_phys < target && guard < 200) begin
      cycle();
      guard++;
    end
    check("wait_bound", guard < 200, 1);
  endtask

  initial begin
    int p, g;
    bus.iSpaceState = 2'd0;
    model_reset();
    m_phys = 0;
    #12;
    check("rst_state", bus.oState, 0);
    check("rst_y", bus.oBirdY, 228);
    check("rst_score", bus.oScore, 0);
    check("rst_ack", bus.oKeyAck, 0);
    check("rst_tick", bus.oFrameTick, 0);
    resetn = 1'b1;
    cycle(); cycle();

    // Start flap from IDLE
    p = m_phys;
    bus.iSpaceState = 2'd1;
    cycle();
    check("start_ack_hi", bus.oKeyAck, 1);
    cycle();
    check("start_ack_lo", bus.oKeyAck, 0);
    check("start_play", bus.oState, 1);
    wait_phys_to(p + 1); check("flap_y1", bus.oBirdY, 220);
    wait_phys_to(p + 2); check("flap_y2", bus.oBirdY, 213);
    wait_phys_to(p + 3); check("flap_y3", bus.oBirdY, 207);

    // Free fall to the floor
    g = 0;
    while (m_state != 2 && g < 1000) begin cycle(); g++; end
    check("fall_bound", g < 1000, 1);
    check("floor_y", bus.oBirdY, 456);
    check("floor_dead", bus.oState, 2);
    check("floor_score", bus.oScore, 12);
    repeat (20) cycle();
    check("frozen_y", bus.oBirdY, 456);
    check("frozen_score", bus.oScore, 12);

    // Make in DEAD returns to IDLE, score kept
    press(2'd1);
    check("dead_to_idle", bus.oState, 0);
    check("idle_y", bus.oBirdY, 228);
    check("idle_score", bus.oScore, 12);

    // Break and code 3 while playing
    press(2'd1);
    check("replay_score", bus.oScore, 0);
    bus.iSpaceState = 2'd2;
    cycle();
    check("break_ack", bus.oKeyAck, 1);
    cycle();
    bus.iSpaceState = 2'd3;
    repeat (3) begin
      cycle();
      check("code3_no_ack", bus.oKeyAck, 0);
    end
    bus.iSpaceState = 2'd0;
    repeat (5) cycle();

    // Asynchronous reset in the middle of play
    #2;
    resetn = 1'b0;
    #1;
    check("arst_state", bus.oState, 0);
    check("arst_y", bus.oBirdY, 228);
    check("arst_score", bus.oScore, 0);
    check("arst_ack", bus.oKeyAck, 0);
    check("arst_tick", bus.oFrameTick, 0);
    model_reset();
    cycle(); cycle();
    resetn = 1'b1;
    cycle();

    // Flap every frame up into the ceiling; also scores 3 after 9 ticks
    p = m_phys;
    press(2'd1);
    wait_phys_to(p + 1);
    check("ceil_y1", bus.oBirdY, 220);
    for (int i = 2; i <= 29; i++) begin
      p = m_phys;
      press(2'd1);
      wait_phys_to(p + 1);
      if (i == 9) check("score_9ticks", bus.oScore, 3);
      if (i == 28) check("ceil_y28", bus.oBirdY, 4);
    end
    check("ceil_y0", bus.oBirdY, 0);
    check("ceil_alive", bus.oState, 1);
    p = m_phys;
    wait_phys_to(p + 1);
    check("ceil_vel0", bus.oBirdY, 1);

    // Random keyboard traffic over many games
    rand_mode = 1'b1;
    repeat (4000) cycle();
    rand_mode = 1'b0;
    bus.iSpaceState = 2'd0;
    cycle(); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
